// File: rtl/stl_pkg.sv
// rtl/stl_pkg.sv - register indices and channel state encoding for speed_table_loader
package stl_pkg;

    localparam int REG_CTRL = 30;
    localparam int REG_DATA = 31;
    localparam int REG_SEL  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } stl_state_e;

endpackage

// File: rtl/stl_channel.sv
// rtl/stl_channel.sv - one channel: load FSM, write pointer, overflow flag
module stl_channel
    import stl_pkg::*;
#(
    parameter int C_TABLE_AW = 10
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ctrl_wr,
    input  logic                ctrl_bit,
    input  logic                data_wr,
    output logic                init,
    output logic                loading,
    output logic                wr_strobe,
    output logic [C_TABLE_AW:0] ptr,
    output logic                ovf
);

    localparam logic [C_TABLE_AW:0] LAST_ADDR = {1'b0, {C_TABLE_AW{1'b1}}};

    stl_state_e state, state_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_wr && ctrl_bit) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (ctrl_wr && !ctrl_bit) begin
                    state_nxt = ST_IDLE;
                end else if (data_wr && ptr == LAST_ADDR) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: if (ctrl_wr && !ctrl_bit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointer doubles as the loaded word count, so it is one bit wider than the address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr       <= '0;
            ovf       <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (state == ST_IDLE && ctrl_wr && ctrl_bit) begin
                ptr <= '0;
                ovf <= 1'b0;
            end else if (state == ST_LOAD && data_wr) begin
                wr_strobe <= 1'b1;
                ptr       <= ptr + 1'b1;
            end else if (state == ST_FULL && data_wr) begin
                ovf <= 1'b1;
            end
        end
    end

    assign init    = (state != ST_IDLE);
    assign loading = (state == ST_LOAD);

endmodule

// File: rtl/speed_table_loader.sv
// rtl/speed_table_loader.sv - register-driven speed table loader; SPEED_TABLE_LOADER_ZPSYNC_EN adds a zpsign synchronizer
module speed_table_loader
    import stl_pkg::*;
#(
    parameter int C_REG_IDX_WIDTH    = 8,
    parameter int C_SPEED_DATA_WIDTH = 16,
    parameter int C_CHANNELS         = 2,
    parameter int C_TABLE_AW         = 10
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    wr_en,
    input  logic [C_REG_IDX_WIDTH-1:0]              wr_addr,
    input  logic [31:0]                             wr_data,
    output logic [C_CHANNELS-1:0]                   br_init,
    output logic [C_CHANNELS-1:0]                   br_wr_en,
    output logic [C_TABLE_AW-1:0]                   br_addr,
    output logic [C_SPEED_DATA_WIDTH-1:0]           br_data,
    output logic [C_CHANNELS*(C_TABLE_AW+1)-1:0]    br_size,
    output logic [C_CHANNELS-1:0]                   br_ovf,
    input  logic [C_CHANNELS-1:0]                   motor_zpsign,
    output logic [C_CHANNELS-1:0]                   motor_zpevent
);

    logic                  ctrl_wr, data_wr, sel_wr;
    logic [1:0]            sel_q;
    logic [C_CHANNELS-1:0] loading;
    logic [C_TABLE_AW:0]   ptr_arr [C_CHANNELS];
    logic [C_TABLE_AW:0]   sel_ptr;
    logic                  sel_loading;
    logic                  unused_bits;

    assign ctrl_wr = wr_en && (wr_addr == C_REG_IDX_WIDTH'(REG_CTRL));
    assign data_wr = wr_en && (wr_addr == C_REG_IDX_WIDTH'(REG_DATA));
    assign sel_wr  = wr_en && (wr_addr == C_REG_IDX_WIDTH'(REG_SEL));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q <= 2'd0;
        end else if (sel_wr) begin
            sel_q <= wr_data[1:0];
        end
    end

    // A SEL value with no matching channel selects nothing, so its DATA writes vanish.
    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
        stl_channel #(
            .C_TABLE_AW(C_TABLE_AW)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .ctrl_wr  (ctrl_wr),
            .ctrl_bit (wr_data[i]),
            .data_wr  (data_wr && (sel_q == 2'(i))),
            .init     (br_init[i]),
            .loading  (loading[i]),
            .wr_strobe(br_wr_en[i]),
            .ptr      (ptr_arr[i]),
            .ovf      (br_ovf[i])
        );
        assign br_size[i*(C_TABLE_AW+1) +: (C_TABLE_AW+1)] = ptr_arr[i];
    end

    always_comb begin
        sel_ptr     = '0;
        sel_loading = 1'b0;
        for (int i = 0; i < C_CHANNELS; i++) begin
            if (sel_q == 2'(i)) begin
                sel_ptr     = ptr_arr[i];
                sel_loading = loading[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_addr <= '0;
            br_data <= '0;
        end else if (data_wr && sel_loading) begin
            br_addr <= sel_ptr[C_TABLE_AW-1:0];
            br_data <= wr_data[C_SPEED_DATA_WIDTH-1:0];
        end
    end

    assign unused_bits = ^{wr_data, sel_ptr[C_TABLE_AW]};

    logic [C_CHANNELS-1:0] zp_src, zp_q;

`ifdef SPEED_TABLE_LOADER_ZPSYNC_EN
    logic [C_CHANNELS-1:0] zp_meta, zp_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zp_meta <= '0;
            zp_sync <= '0;
        end else begin
            zp_meta <= motor_zpsign;
            zp_sync <= zp_meta;
        end
    end
    assign zp_src = zp_sync;
`else
    assign zp_src = motor_zpsign;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zp_q          <= '0;
            motor_zpevent <= '0;
        end else begin
            zp_q          <= zp_src;
            motor_zpevent <= zp_src & ~zp_q;
        end
    end

endmodule

// File: tb/tb_speed_table_loader.sv
// tb/tb_speed_table_loader.sv - scoreboard bench for speed_table_loader (default and 4-deep table instances)
module tb_speed_table_loader;

    localparam int AW  = 10;
    localparam int AW2 = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  zpsign = '0;

    logic [1:0]      init, wen, ovf, zpev;
    logic [AW-1:0]   addr;
    logic [15:0]     data;
    logic [21:0]     size;
    logic [1:0]      init2, wen2, ovf2, zpev2;
    logic [AW2-1:0]  addr2;
    logic [15:0]     data2;
    logic [5:0]      size2;

    speed_table_loader #(.C_TABLE_AW(AW)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .br_init(init), .br_wr_en(wen), .br_addr(addr), .br_data(data), .br_size(size),
        .br_ovf(ovf), .motor_zpsign(zpsign), .motor_zpevent(zpev)
    );

    speed_table_loader #(.C_TABLE_AW(AW2)) dut_small (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .br_init(init2), .br_wr_en(wen2), .br_addr(addr2), .br_data(data2), .br_size(size2),
        .br_ovf(ovf2), .motor_zpsign(zpsign), .motor_zpevent(zpev2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int addr;
        int data;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    bit m_load[2];
    int m_ptr[2];
    int m_sel;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(int a, int d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 8'(a);
        wr_data = d;
        if (a == 30) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!m_load[ch] && ((d >> ch) & 1) == 1) m_ptr[ch] = 0;
                m_load[ch] = ((d >> ch) & 1) == 1;
            end
        end else if (a == 32) begin
            m_sel = d & 3;
        end else if (a == 31) begin
            if (m_sel < 2 && m_load[m_sel] && m_ptr[m_sel] < (1 << AW)) begin
                sbq.push_back('{m_sel, m_ptr[m_sel], d & 16'hffff, cyc + 1});
                m_ptr[m_sel]++;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    int   d_total = 0;
    exp_t e;
    always @(negedge clk) begin
        if (wen !== 2'b00) begin
            d_total++;
            check("onehot_wr_en", 64'($onehot(wen)), 64'd1);
            if (sbq.size() == 0) begin
                check("unexpected_strobe", 64'(wen), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("strobe_ch", 64'(wen), 64'(2'b01 << e.ch));
                check("strobe_addr", 64'(addr), 64'(e.addr));
                check("strobe_data", 64'(data), 64'(e.data));
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    int s_total = 0;
    int s_base = 0;
    bit s_on = 1'b0;
    always @(negedge clk) begin
        if (wen2 !== 2'b00) begin
            if (s_on) check("small_strobe_addr", 64'(addr2), 64'((s_total - s_base) & 3));
            s_total++;
        end
    end

    int zp_cnt = 0;
    int zp_last = 0;
    always @(negedge clk) begin
        if (zpev[0] === 1'b1) begin
            zp_cnt++;
            zp_last = cyc;
        end
    end

    int base, t0, zp_lat;

    initial begin
`ifdef SPEED_TABLE_LOADER_ZPSYNC_EN
        zp_lat = 3;
`else
        zp_lat = 1;
`endif
        m_sel = 0;
        idle(3);
        check("rst_init", 64'(init), 64'd0);
        check("rst_wr_en", 64'(wen), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_size", 64'(size), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_zpevent", 64'(zpev), 64'd0);
        resetn = 1'b1;
        idle(2);

        // 15 words with random gaps into channel 0
        wr(30, 1);
        check("load_init", 64'(init), 64'd1);
        wr(32, 0);
        for (int n = 0; n < 15; n++) begin
            wr(31, n);
            idle($urandom_range(0, 3));
        end
        check("load_size_before_stop", 64'(size[10:0]), 64'd15);
        wr(30, 0);
        check("stop_init_fall", 64'(init[0]), 64'd0);
        check("stop_size", 64'(size[10:0]), 64'd15);
        check("stop_queue_empty", 64'(sbq.size()), 64'd0);

        // interleaved two-channel load
        wr(30, 3);
        for (int n = 0; n < 10; n++) begin
            wr(32, n % 2);
            wr(31, 32'hA000 + n);
        end
        check("dual_size0", 64'(size[10:0]), 64'd5);
        check("dual_size1", 64'(size[21:11]), 64'd5);
        wr(30, 0);
        check("dual_init_off", 64'(init), 64'd0);

        // writes to idle channels and to a nonexistent channel
        base = d_total;
        wr(32, 0); wr(31, 16'h1111);
        wr(32, 1); wr(31, 16'h2222);
        idle(2);
        check("idle_no_strobes", 64'(d_total - base), 64'd0);
        check("idle_size", 64'(size), 64'({11'd5, 11'd5}));
        check("idle_ovf", 64'(ovf), 64'd0);
        wr(30, 3);
        wr(32, 3);
        base = d_total;
        for (int n = 0; n < 4; n++) wr(31, 16'h3300 + n);
        idle(2);
        check("sel3_no_strobes", 64'(d_total - base), 64'd0);
        check("sel3_size", 64'(size), 64'd0);
        check("sel3_ovf", 64'(ovf), 64'd0);
        wr(30, 0);

        // overflow on the 4-deep instance
        wr(30, 1);
        wr(32, 0);
        s_base = s_total;
        s_on = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wr(31, 16'h0500 + n);
            if (n == 3) begin
                check("small_ovf_at4", 64'(ovf2[0]), 64'd0);
                check("small_size_at4", 64'(size2[2:0]), 64'd4);
                check("small_init_full", 64'(init2[0]), 64'd1);
            end
            if (n == 4) check("small_ovf_at5", 64'(ovf2[0]), 64'd1);
        end
        idle(2);
        s_on = 1'b0;
        check("small_strobes", 64'(s_total - s_base), 64'd4);
        check("small_size_final", 64'(size2[2:0]), 64'd4);
        wr(30, 0);
        check("small_size_hold", 64'(size2[2:0]), 64'd4);
        check("small_idle", 64'(init2[0]), 64'd0);
        wr(30, 1);
        check("small_ovf_clear", 64'(ovf2[0]), 64'd0);
        check("small_size_clear", 64'(size2[2:0]), 64'd0);

        // reset in the middle of a load
        for (int n = 0; n < 5; n++) wr(31, 16'h0700 + n);
        check("pre_reset_size", 64'(size[10:0]), 64'd5);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_init", 64'(init), 64'd0);
        check("mid_rst_wr_en", 64'(wen), 64'd0);
        check("mid_rst_addr", 64'(addr), 64'd0);
        check("mid_rst_data", 64'(data), 64'd0);
        check("mid_rst_size", 64'(size), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        check("mid_rst_small_init", 64'(init2), 64'd0);
        check("mid_rst_small_size", 64'(size2), 64'd0);
        check("mid_rst_queue", 64'(sbq.size()), 64'd0);
        m_load[0] = 1'b0; m_load[1] = 1'b0;
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_sel = 0;
        idle(2);
        resetn = 1'b1;
        base = d_total;
        for (int n = 0; n < 3; n++) wr(31, 16'h0800 + n);
        idle(2);
        check("post_rst_no_strobes", 64'(d_total - base), 64'd0);
        check("post_rst_size", 64'(size), 64'd0);
        wr(30, 1);
        wr(31, 32'h0001_2345);
        idle(2);
        check("restart_strobes", 64'(d_total - base), 64'd1);
        check("restart_size", 64'(size[10:0]), 64'd1);
        wr(30, 0);

        // zero-point edge detection
        idle(3);
        base = zp_cnt;
        @(negedge clk);
        zpsign[0] = 1'b1;
        t0 = cyc;
        idle(1000);
        check("zp_pulse_count", 64'(zp_cnt - base), 64'd1);
        check("zp_latency", 64'(zp_last - t0), 64'(zp_lat));
        zpsign[0] = 1'b0;
        idle(4);

        check("final_queue_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_table_loader.md
SPEED_TABLE_LOADER -- requirements
Module: speed_table_loader

Interface
REQ-001 The module SHALL have parameter C_REG_IDX_WIDTH, default 8, the register index width.
REQ-002 The module SHALL have parameter C_SPEED_DATA_WIDTH, default 16, the speed-table word width.
REQ-003 The module SHALL have parameter C_CHANNELS, default 2, the motor channel count (legal 1..4).
REQ-004 The module SHALL have parameter C_TABLE_AW, default 10, the table address width; depth is 2**C_TABLE_AW.
REQ-005 The module SHALL have input clk, 1 bit, the single clock.
REQ-006 The module SHALL have input resetn, 1 bit, reset; it is asynchronous and active-low.
REQ-007 The module SHALL have input wr_en, 1 bit, register write strobe.
REQ-008 The module SHALL have input wr_addr, C_REG_IDX_WIDTH bits, register index.
REQ-009 The module SHALL have input wr_data, 32 bits, register write data.
REQ-010 The module SHALL have output br_init, C_CHANNELS bits, per-channel table-load-in-progress.
REQ-011 The module SHALL have output br_wr_en, C_CHANNELS bits, per-channel table write strobe.
REQ-012 The module SHALL have output br_addr, C_TABLE_AW bits, shared table write address.
REQ-013 The module SHALL have output br_data, C_SPEED_DATA_WIDTH bits, shared table write data.
REQ-014 The module SHALL have output br_size, C_CHANNELS*(C_TABLE_AW+1) bits, packed per-channel loaded word count.
REQ-015 The module SHALL have output br_ovf, C_CHANNELS bits, per-channel sticky overflow flag.
REQ-016 The module SHALL have input motor_zpsign, C_CHANNELS bits, per-channel motor zero-point sensor level.
REQ-017 The module SHALL have output motor_zpevent, C_CHANNELS bits, one-cycle pulse on each zpsign rising edge.

Function
REQ-018 The register map SHALL be: 30 = CTRL (wr_data[C_CHANNELS-1:0] is the per-channel init request); 31 = DATA (wr_data[C_SPEED_DATA_WIDTH-1:0]); 32 = SEL (wr_data[1:0] is the DATA target channel). All other indices SHALL be ignored.
REQ-019 Each channel SHALL run an FSM with states IDLE, LOAD and FULL.
REQ-020 The FSM SHALL go IDLE->LOAD when a CTRL write sets the channel's bit; on entry, the write pointer, br_size and br_ovf SHALL clear to 0.
REQ-021 The FSM SHALL go LOAD->IDLE or FULL->IDLE when a CTRL write clears the channel's bit; br_size SHALL then hold the final pointer value.
REQ-022 A CTRL write with the bit still set while in LOAD or FULL SHALL NOT restart the load.
REQ-023 br_init[i] SHALL be 1 exactly while channel i is in LOAD or FULL.
REQ-024 A DATA write whose SEL channel is in LOAD SHALL, in the next cycle, assert br_wr_en[sel] for one cycle, with br_addr = pointer and br_data = wr_data truncated; the pointer SHALL then increment. Latency is 1 cycle.
REQ-025 When the pointer reaches 2**C_TABLE_AW, the channel SHALL enter FULL.
REQ-026 A DATA write to a channel in FULL SHALL be dropped with no strobe and SHALL set br_ovf.
REQ-027 A DATA write to an IDLE channel, or with SEL >= C_CHANNELS, SHALL be dropped silently.
REQ-028 br_size[i] SHALL equal channel i's pointer at all times (width C_TABLE_AW+1, so a full table reads 2**C_TABLE_AW).
REQ-029 At most one br_wr_en bit SHALL be high in any cycle.
REQ-030 motor_zpevent[i] SHALL pulse for one cycle on each 0->1 transition of the sampled zpsign; a level held high SHALL give no further pulses.

Reset
REQ-031 On resetn low, all FSMs SHALL go IDLE, and br_init, br_wr_en, br_addr, br_data, br_size, br_ovf, motor_zpevent, SEL and the zpsign sample registers SHALL go to 0.
REQ-032 Reset in mid-load SHALL abandon the load with no further strobes; after resetn rises, operation SHALL restart from CTRL.

Configuration
REQ-033 With `SPEED_TABLE_LOADER_ZPSYNC_EN` defined, motor_zpsign SHALL pass a 2-flop synchronizer before edge detection, so motor_zpevent is 3 cycles after the edge.
REQ-034 Without `SPEED_TABLE_LOADER_ZPSYNC_EN`, motor_zpsign SHALL be sampled by one register, so motor_zpevent is 1 cycle after the edge.

Structure
REQ-035 A shared package stl_pkg SHALL hold the register indices (30, 31, 32) and the IDLE/LOAD/FULL state enum.
REQ-036 The per-channel FSM, pointer, size and overflow logic SHALL be the sub-module stl_channel, instantiated C_CHANNELS times; write muxing and zpsign logic SHALL stay at top level.

Verification
REQ-037 CTRL=1, SEL=0, DATA 0..14 at random gaps, then CTRL=0 -> 15 br_wr_en[0] strobes at addresses 0..14 with data 0..14, br_size[0]=15, br_init[0] falls 1 cycle after the CTRL write.
REQ-038 C_TABLE_AW=2, CTRL=1, 6 DATA writes -> 4 strobes, br_size[0]=4, br_ovf[0]=1 after the 5th write; a new CTRL=0 then CTRL=1 clears br_ovf and br_size.
REQ-039 CTRL=3, alternate SEL 0/1 with DATA 0xA000+n -> each channel receives only its own words at consecutive addresses, and no cycle has two br_wr_en bits high.
REQ-040 DATA writes with all channels IDLE, and with SEL=3 when C_CHANNELS=2 -> no strobes, and br_size/br_ovf unchanged.
REQ-041 resetn pulsed low after 5 words into a load -> all outputs 0 at once and no strobes until a new CTRL write.
REQ-042 motor_zpsign[0] 0->1 held for 1000 cycles -> exactly one motor_zpevent[0] pulse, 1 cycle after the edge without the macro and 3 cycles after it with the macro.
